// File: rtl/rob_buffer_pkg.sv
// Shared constants and types for the reorder buffer slice.
// Imported by rob_ptr_ctrl and rob_buffer.
package rob_buffer_pkg;

    localparam int ROB_Size  = 16;
    localparam int ROB_Width = 4;
    localparam int Data_Bus  = 32;

    typedef enum logic [1:0] {
        KIND_REG    = 2'd0,
        KIND_STORE  = 2'd1,
        KIND_BRANCH = 2'd2,
        KIND_JUMP   = 2'd3
    } rob_kind_e;

    localparam logic [ROB_Width-1:0] EMPTY_TAG = '0;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/count bookkeeping for the reorder buffer, plus the
// circular "younger than the flushed branch" mask.
module rob_ptr_ctrl
    import rob_buffer_pkg::*;
#(
    parameter int DEPTH = ROB_Size,
    parameter int AW    = ROB_Width
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          alloc_req_i,
    input  logic          clr_i,
    input  logic [AW-1:0] clear_tag_i,
    input  logic          commit_i,
    output logic [AW-1:0] head_o,
    output logic [AW-1:0] tail_o,
    output logic          full_o,
    output logic          alloc_fire_o,
    output logic [DEPTH-1:0] young_o
);

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] off_c;
    logic [AW-1:0] idx;
    logic [AW-1:0] off_i;

    assign head_o = head_q;
    assign tail_o = tail_q;
    assign full_o = (count_q == (AW+1)'(DEPTH));
    assign alloc_fire_o = rdy & alloc_req_i & ~full_o & ~clr_i;

    // Age is the distance from head; anything further than the branch is younger.
    always_comb begin
        off_c = clear_tag_i - head_q;
        idx   = '0;
        off_i = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx        = AW'(i);
            off_i      = idx - head_q;
            young_o[i] = (off_i > off_c);
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy) begin
            if (commit_i) begin
                head_d = head_q + 1'b1;
            end
            if (clr_i) begin
                tail_d  = clear_tag_i + 1'b1;
                count_d = {1'b0, off_c} + (AW+1)'(1)
                        - (AW+1)'(commit_i);
            end else begin
                if (alloc_fire_o) begin
                    tail_d = tail_q + 1'b1;
                end
                count_d = count_q + (AW+1)'(alloc_fire_o)
                        - (AW+1)'(commit_i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rob_buffer.sv
// Reorder buffer: in-order tag allocation, RS writeback capture, broadcast, commit.
// Define ROB_BYPASS_EN to forward an accepted writeback onto the broadcast bus combinationally.
module rob_buffer
    import rob_buffer_pkg::*;
#(
    parameter int ROB_DEPTH = ROB_Size,
    parameter int ADDR_W    = ROB_Width,
    parameter int DATA_W    = Data_Bus
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      alloc_req,
    input  logic [4:0]                alloc_rd,
    input  logic [1:0]                alloc_kind,
    output logic [ADDR_W-1:0]         alloc_tag,
    output logic                      full,
    input  logic                      ROB_Ready,
    input  logic [ADDR_W-1:0]         ROB_Addr,
    input  logic [DATA_W-1:0]         ROB_A,
    input  logic                      clr,
    input  logic [ADDR_W-1:0]         Clear_Tag,
    output logic [ROB_DEPTH-1:0]      ROB_Valid,
    output logic [ROB_DEPTH*DATA_W-1:0] ROB_Value,
    input  logic                      commit_ready,
    output logic                      commit_valid,
    output logic [ADDR_W-1:0]         commit_tag,
    output logic [4:0]                commit_rd,
    output logic [1:0]                commit_kind,
    output logic [DATA_W-1:0]         commit_value
);

    logic [ROB_DEPTH-1:0] busy_q, busy_d;
    logic [ROB_DEPTH-1:0] done_q, done_d;
    logic [DATA_W-1:0]    value_q [ROB_DEPTH];
    logic [DATA_W-1:0]    value_d [ROB_DEPTH];
    logic [4:0]           rd_q    [ROB_DEPTH];
    logic [4:0]           rd_d    [ROB_DEPTH];
    rob_kind_e            kind_q  [ROB_DEPTH];
    rob_kind_e            kind_d  [ROB_DEPTH];

    logic                 cv_q;
    logic [ADDR_W-1:0]    ctag_q;
    logic [4:0]           crd_q;
    logic [1:0]           ckind_q;
    logic [DATA_W-1:0]    cval_q;

    logic [ADDR_W-1:0]    head;
    logic [ADDR_W-1:0]    tail;
    logic [ROB_DEPTH-1:0] young;
    logic                 alloc_fire;
    logic                 commit_fire;
    logic                 wb_ok;

    rob_ptr_ctrl #(
        .DEPTH (ROB_DEPTH),
        .AW    (ADDR_W)
    ) u_ptr (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .alloc_req_i  (alloc_req),
        .clr_i        (clr),
        .clear_tag_i  (Clear_Tag),
        .commit_i     (commit_fire),
        .head_o       (head),
        .tail_o       (tail),
        .full_o       (full),
        .alloc_fire_o (alloc_fire),
        .young_o      (young)
    );

    assign alloc_tag   = tail;
    // done must already be registered, so a same-cycle writeback to head waits a cycle.
    assign commit_fire = rdy & busy_q[head] & done_q[head] & commit_ready;
    assign wb_ok       = rdy & ROB_Ready & busy_q[ROB_Addr]
                       & ~(clr & young[ROB_Addr]);

    always_comb begin
        busy_d  = busy_q;
        done_d  = done_q;
        value_d = value_q;
        rd_d    = rd_q;
        kind_d  = kind_q;
        if (rdy) begin
            if (wb_ok) begin
                done_d[ROB_Addr]  = 1'b1;
                value_d[ROB_Addr] = ROB_A;
            end
            if (clr) begin
                if (busy_q[Clear_Tag]) begin
                    done_d[Clear_Tag] = 1'b1;
                end
                busy_d = busy_d & ~young;
                done_d = done_d & ~young;
            end
            if (alloc_fire) begin
                busy_d[tail]  = 1'b1;
                done_d[tail]  = 1'b0;
                rd_d[tail]    = alloc_rd;
                kind_d[tail]  = rob_kind_e'(alloc_kind);
                value_d[tail] = '0;
            end
            if (commit_fire) begin
                busy_d[head] = 1'b0;
                done_d[head] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            done_q  <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                value_q[i] <= '0;
                rd_q[i]    <= '0;
                kind_q[i]  <= KIND_REG;
            end
            cv_q    <= 1'b0;
            ctag_q  <= EMPTY_TAG;
            crd_q   <= '0;
            ckind_q <= '0;
            cval_q  <= '0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            value_q <= value_d;
            rd_q    <= rd_d;
            kind_q  <= kind_d;
            cv_q    <= commit_fire;
            if (commit_fire) begin
                ctag_q  <= head;
                crd_q   <= rd_q[head];
                ckind_q <= kind_q[head];
                cval_q  <= value_q[head];
            end
        end
    end

    assign commit_valid = cv_q;
    assign commit_tag   = ctag_q;
    assign commit_rd    = crd_q;
    assign commit_kind  = ckind_q;
    assign commit_value = cval_q;

    always_comb begin
        ROB_Valid = busy_q & done_q;
        ROB_Value = '0;
        for (int i = 0; i < ROB_DEPTH; i++) begin
            ROB_Value[i*DATA_W +: DATA_W] = value_q[i];
        end
`ifdef ROB_BYPASS_EN
        if (wb_ok) begin
            ROB_Valid[ROB_Addr] = 1'b1;
            ROB_Value[int'(ROB_Addr)*DATA_W +: DATA_W] = ROB_A;
        end
`endif
    end

endmodule

// File: tb/tb_rob_buffer.sv
// Randomized and directed bench for rob_buffer against a queue-based program-order model.
// Honors ROB_BYPASS_EN the same way the design does.
module tb_rob_buffer;

    localparam int D  = 16;
    localparam int AW = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            rdy;
    logic            alloc_req;
    logic [4:0]      alloc_rd;
    logic [1:0]      alloc_kind;
    logic [AW-1:0]   alloc_tag;
    logic            full;
    logic            ROB_Ready;
    logic [AW-1:0]   ROB_Addr;
    logic [DW-1:0]   ROB_A;
    logic            clr;
    logic [AW-1:0]   Clear_Tag;
    logic [D-1:0]    ROB_Valid;
    logic [D*DW-1:0] ROB_Value;
    logic            commit_ready;
    logic            commit_valid;
    logic [AW-1:0]   commit_tag;
    logic [4:0]      commit_rd;
    logic [1:0]      commit_kind;
    logic [DW-1:0]   commit_value;

    rob_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .alloc_req    (alloc_req),
        .alloc_rd     (alloc_rd),
        .alloc_kind   (alloc_kind),
        .alloc_tag    (alloc_tag),
        .full         (full),
        .ROB_Ready    (ROB_Ready),
        .ROB_Addr     (ROB_Addr),
        .ROB_A        (ROB_A),
        .clr          (clr),
        .Clear_Tag    (Clear_Tag),
        .ROB_Valid    (ROB_Valid),
        .ROB_Value    (ROB_Value),
        .commit_ready (commit_ready),
        .commit_valid (commit_valid),
        .commit_tag   (commit_tag),
        .commit_rd    (commit_rd),
        .commit_kind  (commit_kind),
        .commit_value (commit_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tag;
        int rd;
        int kind;
        bit done;
    } ent_t;

    ent_t q[$];
    int   slot_val [D];
    int   next_tag;
    bit   exp_cv;
    int   exp_ct, exp_crd, exp_ckind, exp_cval;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int find(input int tag);
        for (int i = 0; i < q.size(); i++)
            if (q[i].tag == tag) return i;
        return -1;
    endfunction

    function automatic bit wb_accepted();
        int w, c;
        w = find(int'(ROB_Addr));
        c = clr ? find(int'(Clear_Tag)) : -1;
        return rdy && ROB_Ready && (w >= 0) && !(clr && w > c);
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < D; i++) slot_val[i] = 0;
        next_tag = 0;
        exp_cv = 0;
    endtask

    task automatic model_edge();
        bit cm;
        int w, c;
        ent_t e;
        exp_cv = 0;
        if (!rdy) return;
        cm = (q.size() > 0) && q[0].done && commit_ready;
        if (cm) begin
            exp_ct    = q[0].tag;
            exp_crd   = q[0].rd;
            exp_ckind = q[0].kind;
            exp_cval  = slot_val[q[0].tag];
        end
        w = find(int'(ROB_Addr));
        c = clr ? find(int'(Clear_Tag)) : -1;
        if (wb_accepted()) begin
            q[w].done = 1;
            slot_val[ROB_Addr] = int'(ROB_A);
        end
        if (clr) begin
            if (c >= 0) q[c].done = 1;
            while (q.size() > c + 1) void'(q.pop_back());
            next_tag = (int'(Clear_Tag) + 1) % D;
        end else if (alloc_req && q.size() < D) begin
            e.tag = next_tag;
            e.rd = int'(alloc_rd);
            e.kind = int'(alloc_kind);
            e.done = 0;
            q.push_back(e);
            slot_val[next_tag] = 0;
            next_tag = (next_tag + 1) % D;
        end
        if (cm) void'(q.pop_front());
        exp_cv = cm;
    endtask

    task automatic idle();
        rdy = 1; alloc_req = 0; alloc_rd = 0; alloc_kind = 0;
        ROB_Ready = 0; ROB_Addr = 0; ROB_A = 0;
        clr = 0; Clear_Tag = 0; commit_ready = 0;
    endtask

    // Called at negedge with inputs applied; checks both sides of the edge.
    task automatic step();
        logic [D-1:0] ev;
        logic [DW-1:0] evals [D];
        #1;
        ev = '0;
        for (int i = 0; i < D; i++) evals[i] = slot_val[i];
        foreach (q[i]) if (q[i].done) ev[q[i].tag] = 1'b1;
`ifdef ROB_BYPASS_EN
        if (wb_accepted()) begin
            ev[ROB_Addr] = 1'b1;
            evals[ROB_Addr] = ROB_A;
        end
`endif
        chk("full", full, (q.size() == D));
        chk("alloc_tag", alloc_tag, next_tag);
        chk("rob_valid", ROB_Valid, ev);
        for (int i = 0; i < D; i++)
            if (ev[i]) chk("rob_value", ROB_Value[i*DW +: DW], evals[i]);
        @(posedge clk);
        model_edge();
        #1;
        chk("commit_valid", commit_valid, exp_cv);
        if (exp_cv) begin
            chk("commit_tag", commit_tag, exp_ct);
            chk("commit_rd", commit_rd, exp_crd);
            chk("commit_kind", commit_kind, exp_ckind);
            chk("commit_value", commit_value, exp_cval);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_valid", ROB_Valid, 0);
        chk("rst_full", full, 0);
        chk("rst_tag", alloc_tag, 0);
        chk("rst_cv", commit_valid, 0);
        chk("rst_cval", commit_value, 0);
        @(negedge clk);
    endtask

    task automatic alloc_one(input int rd, input int kind);
        idle();
        alloc_req = 1;
        alloc_rd = 5'(rd);
        alloc_kind = 2'(kind);
        step();
    endtask

    task automatic wb(input int tag, input int val, input bit cr);
        idle();
        ROB_Ready = 1;
        ROB_Addr = AW'(tag);
        ROB_A = DW'(val);
        commit_ready = cr;
        step();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            idle();
            commit_ready = 1;
            step();
        end
    endtask

    initial begin
        rst = 1;
        idle();
        do_reset();

        for (int i = 0; i < D; i++) begin
            chk("fill_tag", alloc_tag, i);
            alloc_one(i + 1, i % 4);
        end
        chk("fill_full", full, 1);
        alloc_one(7, 0);
        chk("fill_tail", alloc_tag, 0);

        do_reset();
        alloc_one(3, 0);
        alloc_one(4, 1);
        wb(1, 'h55, 1);
        wb(0, 'h11, 1);
        drain(4);

        do_reset();
        for (int i = 0; i < 14; i++) alloc_one(1, 0);
        for (int i = 0; i < 14; i++) wb(i, i * 3, 1);
        drain(4);
        chk("wrap_head", alloc_tag, 14);
        for (int i = 0; i < 4; i++) alloc_one(i + 8, 3);
        for (int i = 0; i < 4; i++) wb((14 + i) % D, 'hA0 + i, 1);
        drain(4);
        chk("wrap_empty", full, 0);
        chk("wrap_tail", alloc_tag, 2);

        do_reset();
        for (int i = 0; i < 6; i++) alloc_one(i + 1, (i == 2) ? 2 : 0);
        idle();
        clr = 1;
        Clear_Tag = 2;
        step();
        chk("flush_tail", alloc_tag, 3);
        wb(4, 'hDEAD, 0);
        chk("flush_wb4", ROB_Valid[4], 0);

        do_reset();
        alloc_one(9, 0);
        wb(0, 'h77, 0);
        drain(0);
        for (int i = 0; i < 3; i++) begin idle(); step(); end
        drain(2);

        do_reset();
        alloc_one(5, 0);
        alloc_one(6, 0);
        idle();
        rdy = 0; ROB_Ready = 1; ROB_Addr = 0; ROB_A = 'h99;
        commit_ready = 1;
        step();
        wb(0, 'h12, 1);
        idle();
        rdy = 0; commit_ready = 1;
        step();
        drain(2);

        for (int n = 0; n < 3000; n++) begin
            idle();
            rdy = ($urandom_range(0, 9) != 0);
            alloc_req = $urandom_range(0, 1);
            alloc_rd = 5'($urandom);
            alloc_kind = 2'($urandom);
            ROB_Ready = ($urandom_range(0, 9) < 6);
            if (q.size() > 0 && $urandom_range(0, 4) != 0)
                ROB_Addr = AW'(q[$urandom_range(0, q.size() - 1)].tag);
            else
                ROB_Addr = AW'($urandom);
            ROB_A = $urandom;
            commit_ready = ($urandom_range(0, 3) != 0);
            if (q.size() > 0 && $urandom_range(0, 19) == 0) begin
                clr = 1;
                Clear_Tag = AW'(q[$urandom_range(0, q.size() - 1)].tag);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
